// File: rtl/w_rom_pkg.sv
// Shared types and helpers for the banked weight ROM.
package w_rom_pkg;

    typedef enum logic [1:0] {
        W_ROM_IDLE,
        W_ROM_LOAD,
        W_ROM_DONE
    } w_rom_state_e;

    function automatic int unsigned num_units(input int unsigned data_width,
                                              input int unsigned unit_width);
        return data_width / unit_width;
    endfunction

    // Width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/w_rom_unit.sv
// One UNIT_WIDTH x DATA_DEPTH ROM slice: synchronous write, registered read.
// W_ROM_PARITY_EN adds a stored even-parity bit and a read-side check.
module w_rom_unit #(
    parameter int unsigned UNIT_WIDTH = 384,
    parameter int unsigned DATA_DEPTH = 512,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [UNIT_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [UNIT_WIDTH-1:0] rdata
`ifdef W_ROM_PARITY_EN
    ,
    output logic                  perr
`endif
);

`ifdef W_ROM_PARITY_EN
    localparam int unsigned MEM_WIDTH = UNIT_WIDTH + 1;
`else
    localparam int unsigned MEM_WIDTH = UNIT_WIDTH;
`endif

    logic [MEM_WIDTH-1:0] wword;
    logic [MEM_WIDTH-1:0] mem [DATA_DEPTH];
    logic [MEM_WIDTH-1:0] rd_q;

`ifdef W_ROM_PARITY_EN
    assign wword = {^wdata, wdata};
`else
    assign wword = wdata;
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[raddr];
        end
    end

    assign rdata = rd_q[UNIT_WIDTH-1:0];

`ifdef W_ROM_PARITY_EN
    // Even parity over data plus stored bit must come out zero.
    assign perr = ^rd_q;
`endif

endmodule

// File: rtl/w_rom_banked.sv
// Banked weight ROM: burn-in sequencer filling N slices from a narrow stream,
// plus a pipelined full-width read port. Optional parity via W_ROM_PARITY_EN.
module w_rom_banked
    import w_rom_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 4608,
    parameter int unsigned DATA_DEPTH   = 512,
    parameter int unsigned UNIT_WIDTH   = 384,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            burn_in_en,
    input  logic                            load_valid,
    input  logic [UNIT_WIDTH-1:0]           load_data,
    output logic                            load_ready,
    output logic                            burned,
    input  logic                            r_en,
    input  logic [cnt_width(DATA_DEPTH)-1:0] addr_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            r_valid,
    output logic                            r_err
`ifdef W_ROM_PARITY_EN
    ,
    output logic                            parity_err
`endif
);

    localparam int unsigned NUM_UNITS  = num_units(DATA_WIDTH, UNIT_WIDTH);
    localparam int unsigned ADDR_WIDTH = cnt_width(DATA_DEPTH);
    localparam int unsigned UCNT_WIDTH = cnt_width(NUM_UNITS);

`ifdef MODE_SIM
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("w_rom_banked: READ_LATENCY must be 1 or 2");
    end
`endif

    w_rom_state_e          state_q;
    logic [UCNT_WIDTH-1:0] unit_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic                  load_hs;
    logic                  last_word;

    assign load_hs   = load_valid & load_ready;
    assign last_word = (unit_cnt_q == UCNT_WIDTH'(NUM_UNITS - 1)) &&
                       (addr_cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= W_ROM_IDLE;
            unit_cnt_q <= '0;
            addr_cnt_q <= '0;
            load_ready <= 1'b0;
            burned     <= 1'b0;
        end else begin
            case (state_q)
                W_ROM_IDLE: begin
                    if (burn_in_en) begin
                        state_q    <= W_ROM_LOAD;
                        load_ready <= 1'b1;
                        unit_cnt_q <= '0;
                        addr_cnt_q <= '0;
                    end
                end
                W_ROM_LOAD: begin
                    if (load_hs) begin
                        if (unit_cnt_q == UCNT_WIDTH'(NUM_UNITS - 1)) begin
                            unit_cnt_q <= '0;
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                        end else begin
                            unit_cnt_q <= unit_cnt_q + 1'b1;
                        end
                    end
                    // Completing the last word wins over a simultaneous abort.
                    if (load_hs && last_word) begin
                        state_q    <= W_ROM_DONE;
                        load_ready <= 1'b0;
                        burned     <= 1'b1;
                    end else if (!burn_in_en) begin
                        state_q    <= W_ROM_IDLE;
                        load_ready <= 1'b0;
                        unit_cnt_q <= '0;
                        addr_cnt_q <= '0;
                    end
                end
                W_ROM_DONE: ;
                default: state_q <= W_ROM_IDLE;
            endcase
        end
    end

    logic in_range;
    logic rd_acc;
    logic rd_rej;

    if ((1 << ADDR_WIDTH) == DATA_DEPTH) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = addr_in < ADDR_WIDTH'(DATA_DEPTH);
    end

    assign rd_acc = r_en & burned & in_range;
    assign rd_rej = r_en & ~rd_acc;

    logic [DATA_WIDTH-1:0] rdata_cat;
    logic [NUM_UNITS-1:0]  perr_vec;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        w_rom_unit #(
            .UNIT_WIDTH(UNIT_WIDTH),
            .DATA_DEPTH(DATA_DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_unit (
            .clk  (clk),
            .rst_b(rst_b),
            .we   (load_hs && (unit_cnt_q == UCNT_WIDTH'(i))),
            .waddr(addr_cnt_q),
            .wdata(load_data),
            .re   (rd_acc),
            .raddr(addr_in),
            .rdata(rdata_cat[i*UNIT_WIDTH +: UNIT_WIDTH])
`ifdef W_ROM_PARITY_EN
            ,
            .perr (perr_vec[i])
`endif
        );
`ifndef W_ROM_PARITY_EN
        assign perr_vec[i] = 1'b0;
`endif
    end

    logic v1_q;
    logic e1_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
        end else begin
            v1_q <= rd_acc;
            e1_q <= rd_rej;
        end
    end

    logic perr_any;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  v2_q;
        logic                  e2_q;
        logic                  p2_q;
        logic [DATA_WIDTH-1:0] d2_q;

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                p2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                p2_q <= v1_q & (|perr_vec);
                if (v1_q) begin
                    d2_q <= rdata_cat;
                end
            end
        end

        assign r_valid  = v2_q;
        assign r_err    = e2_q;
        assign perr_any = p2_q;
        assign data_out = d2_q;
    end else begin : g_lat1
        // Slice read registers only load on accepted reads, so they hold on rejects.
        assign r_valid  = v1_q;
        assign r_err    = e1_q;
        assign perr_any = v1_q & (|perr_vec);
        assign data_out = rdata_cat;
    end

`ifdef W_ROM_PARITY_EN
    assign parity_err = perr_any;
`else
    logic unused_perr;
    assign unused_perr = perr_any;
`endif

endmodule

// File: tb/tb_w_rom_banked.sv
// Randomised bench for w_rom_banked against a word-level reference model.
// Three instances: depth 4 / latency 1, depth 4 / latency 2, depth 3 / latency 2.
module tb_w_rom_banked;

    localparam int NDUT = 3;
    localparam int N    = 4;

    function automatic int dep(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    logic        clk;
    logic        rst_b;
    logic        burn_in_en [NDUT];
    logic        load_valid [NDUT];
    logic [7:0]  load_data  [NDUT];
    logic        load_ready [NDUT];
    logic        burned     [NDUT];
    logic        r_en       [NDUT];
    logic [1:0]  addr_in    [NDUT];
    logic [31:0] data_out   [NDUT];
    logic        r_valid    [NDUT];
    logic        r_err      [NDUT];
    logic        parity_err [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        w_rom_banked #(
            .DATA_WIDTH  (32),
            .DATA_DEPTH  ((g == 2) ? 3 : 4),
            .UNIT_WIDTH  (8),
            .READ_LATENCY((g == 0) ? 1 : 2)
        ) u_dut (
            .clk       (clk),
            .rst_b     (rst_b),
            .burn_in_en(burn_in_en[g]),
            .load_valid(load_valid[g]),
            .load_data (load_data[g]),
            .load_ready(load_ready[g]),
            .burned    (burned[g]),
            .r_en      (r_en[g]),
            .addr_in   (addr_in[g]),
            .data_out  (data_out[g]),
            .r_valid   (r_valid[g]),
            .r_err     (r_err[g])
`ifdef W_ROM_PARITY_EN
            ,
            .parity_err(parity_err[g])
`endif
        );
`ifndef W_ROM_PARITY_EN
        assign parity_err[g] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as whole words, load progress as a word count.
    bit          m_load   [NDUT];
    bit          m_burned [NDUT];
    int          m_cnt    [NDUT];
    logic [31:0] m_mem    [NDUT][4];
    bit          m_flip   [NDUT][4];
    bit          p_v [NDUT], p_e [NDUT], p_par [NDUT];
    logic [31:0] p_d [NDUT];
    bit          x_v [NDUT], x_e [NDUT], x_par [NDUT];
    logic [31:0] x_dout [NDUT];
    logic [7:0]  src [NDUT][16];

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_burned", d), burned[d], m_burned[d]);
            check($sformatf("d%0d_load_ready", d), load_ready[d], m_load[d]);
            check($sformatf("d%0d_r_valid", d), r_valid[d], x_v[d]);
            check($sformatf("d%0d_r_err", d), r_err[d], x_e[d]);
            check($sformatf("d%0d_data_out", d), data_out[d], x_dout[d]);
`ifdef W_ROM_PARITY_EN
            check($sformatf("d%0d_parity_err", d), parity_err[d], x_par[d]);
`endif
        end
    endtask

    task automatic step();
        bit          hs [NDUT], acc [NDUT], rej [NDUT], en [NDUT], fl [NDUT];
        logic [31:0] rd [NDUT];
        logic [7:0]  ld [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            hs[d]  = load_valid[d] && m_load[d];
            en[d]  = burn_in_en[d];
            ld[d]  = load_data[d];
            acc[d] = r_en[d] && m_burned[d] && (int'(addr_in[d]) < dep(d));
            rej[d] = r_en[d] && !acc[d];
            rd[d]  = acc[d] ? m_mem[d][addr_in[d]] : 32'h0;
            fl[d]  = acc[d] && m_flip[d][addr_in[d]];
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (m_load[d]) begin
                if (hs[d]) begin
                    m_mem[d][m_cnt[d] / N][8 * (m_cnt[d] % N) +: 8] = ld[d];
                    m_cnt[d]++;
                end
                if (m_cnt[d] == dep(d) * N) begin
                    m_load[d]   = 1'b0;
                    m_burned[d] = 1'b1;
                end else if (!en[d]) begin
                    m_load[d] = 1'b0;
                    m_cnt[d]  = 0;
                end
            end else if (!m_burned[d] && en[d]) begin
                m_load[d] = 1'b1;
                m_cnt[d]  = 0;
            end
            if (lat(d) == 1) begin
                x_v[d]   = acc[d];
                x_e[d]   = rej[d];
                x_par[d] = fl[d];
                if (acc[d]) x_dout[d] = rd[d];
            end else begin
                x_v[d]   = p_v[d];
                x_e[d]   = p_e[d];
                x_par[d] = p_par[d];
                if (p_v[d]) x_dout[d] = p_d[d];
                p_v[d]   = acc[d];
                p_e[d]   = rej[d];
                p_par[d] = fl[d];
                p_d[d]   = rd[d];
            end
        end
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        for (int d = 0; d < NDUT; d++) begin
            burn_in_en[d] = 1'b0;
            load_valid[d] = 1'b0;
            load_data[d]  = 8'h0;
            r_en[d]       = 1'b0;
            addr_in[d]    = 2'd0;
        end
        #2 rst_b = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            m_load[d] = 0; m_burned[d] = 0; m_cnt[d] = 0;
            p_v[d] = 0; p_e[d] = 0; p_par[d] = 0; p_d[d] = '0;
            x_v[d] = 0; x_e[d] = 0; x_par[d] = 0; x_dout[d] = '0;
            for (int a = 0; a < 4; a++) m_flip[d][a] = 1'b0;
        end
        compare_all();
        @(negedge clk) rst_b = 1'b1;
    endtask

    task automatic drive(input int d, input bit rand_valid, input bit rand_read);
        load_valid[d] = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        load_data[d]  = src[d][m_cnt[d] % 16];
        if (rand_read) begin
            r_en[d]    = $urandom_range(0, 1) != 0;
            addr_in[d] = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_b = 1'b0;
        pulse_reset();

        // Directed burn-in of 0x00..0x0F on both depth-4 instances.
        for (int k = 0; k < 16; k++) begin
            src[0][k] = 8'(k);
            src[1][k] = 8'(k);
            src[2][k] = 8'($urandom);
        end
        burn_in_en[0] = 1'b1;
        burn_in_en[1] = 1'b1;
        r_en[0]       = 1'b1;
        addr_in[0]    = 2'd0;
        for (int c = 1; c <= 17; c++) begin
            drive(0, 1'b0, 1'b0);
            drive(1, 1'b0, 1'b0);
            step();
            if (c == 1) begin
                check("early_r_err", r_err[0], 1);
                check("early_data_out", data_out[0], 0);
                r_en[0] = 1'b0;
            end
            if (c == 16) check("burned_at_16", burned[0], 0);
        end
        check("burned_at_17", burned[0], 1);
        load_valid[0] = 1'b0;
        load_valid[1] = 1'b0;

        r_en[0] = 1'b1; addr_in[0] = 2'd2;
        step();
        r_en[0] = 1'b0;
        check("rd_a2_valid", r_valid[0], 1);
        check("rd_a2_data", data_out[0], 32'h0B0A0908);

        // Back-to-back reads on the latency-2 instance.
        r_en[1] = 1'b1; addr_in[1] = 2'd3;
        step();
        check("b2b_v_early", r_valid[1], 0);
        addr_in[1] = 2'd0;
        step();
        check("b2b_d3", data_out[1], 32'h0F0E0D0C);
        addr_in[1] = 2'd1;
        step();
        check("b2b_d0", data_out[1], 32'h03020100);
        r_en[1] = 1'b0;
        step();
        check("b2b_d1", data_out[1], 32'h07060504);
        check("b2b_v_last", r_valid[1], 1);
        step();
        check("b2b_v_done", r_valid[1], 0);

        // Random reads, while the depth-3 instance burns in with gaps.
        burn_in_en[2] = 1'b1;
        for (int c = 0; c < 150; c++) begin
            drive(0, 1'b1, 1'b1);
            drive(1, 1'b1, 1'b1);
            drive(2, 1'b1, 1'b1);
            step();
        end
        for (int d = 0; d < NDUT; d++) r_en[d] = 1'b0;
        load_valid[2] = 1'b0;
        check("d2_burned", burned[2], 1);

        r_en[2] = 1'b1; addr_in[2] = 2'd3;
        step();
        r_en[2] = 1'b0;
        step();
        check("oob_r_err", r_err[2], 1);
        check("oob_r_valid", r_valid[2], 0);

        // Reset with a read in flight on the latency-2 depth-3 instance.
        r_en[2] = 1'b1; addr_in[2] = 2'd1;
        step();
        r_en[2] = 1'b0;
        pulse_reset();
        step();
        check("rst_drop_valid", r_valid[2], 0);
        check("rst_burned", burned[2], 0);

        // Abort after 5 words, then a full reload with random gaps.
        for (int k = 0; k < 16; k++) begin
            src[0][k] = 8'($urandom);
            src[1][k] = src[0][k];
        end
        burn_in_en[0] = 1'b1;
        burn_in_en[1] = 1'b1;
        for (int c = 0; c < 20 && m_cnt[0] < 5; c++) begin
            drive(0, 1'b0, 1'b0);
            drive(1, 1'b0, 1'b0);
            step();
        end
        load_valid[0] = 1'b0; load_valid[1] = 1'b0;
        burn_in_en[0] = 1'b0; burn_in_en[1] = 1'b0;
        step();
        step();
        check("abort_burned", burned[0], 0);
        check("abort_ready", load_ready[0], 0);
        for (int k = 0; k < 16; k++) begin
            src[0][k] = 8'($urandom);
            src[1][k] = src[0][k];
        end
        burn_in_en[0] = 1'b1;
        burn_in_en[1] = 1'b1;
        for (int c = 0; c < 200 && !m_burned[0]; c++) begin
            drive(0, 1'b1, 1'b0);
            drive(1, 1'b1, 1'b0);
            step();
        end
        load_valid[0] = 1'b0; load_valid[1] = 1'b0;
        check("reload_burned", burned[0], 1);
        for (int a = 0; a < 4; a++) begin
            r_en[0] = 1'b1; addr_in[0] = 2'(a);
            step();
            check($sformatf("reload_a%0d", a), data_out[0],
                  {src[0][4*a+3], src[0][4*a+2], src[0][4*a+1], src[0][4*a]});
        end
        r_en[0] = 1'b0;

        for (int c = 0; c < 60; c++) begin
            drive(0, 1'b1, 1'b1);
            drive(1, 1'b1, 1'b1);
            step();
        end
        r_en[0] = 1'b0; r_en[1] = 1'b0;

`ifdef W_ROM_PARITY_EN
        // Flip one stored bit in unit 1 at address 0.
        g_dut[0].u_dut.g_unit[1].u_unit.mem[0][0] = ~g_dut[0].u_dut.g_unit[1].u_unit.mem[0][0];
        m_mem[0][0][8] = ~m_mem[0][0][8];
        m_flip[0][0]   = 1'b1;
        r_en[0] = 1'b1; addr_in[0] = 2'd0;
        step();
        r_en[0] = 1'b0;
        check("par_valid", r_valid[0], 1);
        check("par_err", parity_err[0], 1);
        step();
        check("par_err_clear", parity_err[0], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w_rom_banked.md
# w_rom_banked

Parametrised weight ROM built from `NUM_UNITS = DATA_WIDTH / UNIT_WIDTH` narrow memory slices. It has a built-in burn-in sequencer that fills every slice from a narrow valid/ready load stream, and a pipelined, configurable-latency full-width read port. It replaces the fixed-geometry weight ROMs feeding the convolution engines, serving any width, depth or unit split from one module.

## Interface
Parameters:
- `DATA_WIDTH`, 4608: full read word width; must be a multiple of `UNIT_WIDTH`.
- `DATA_DEPTH`, 512: number of words; need not be a power of two.
- `UNIT_WIDTH`, 384: slice width and load-stream width.
- `READ_LATENCY`, 1: cycles from an accepted `r_en` to `r_valid`; legal values are 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `rst_b`  in  1  asynchronous active-low reset.
- `burn_in_en`  in  1  level; requests and holds a burn-in sequence.
- `load_valid`  in  1  load word present.
- `load_data`  in  `UNIT_WIDTH`  load word.
- `load_ready`  out  1  sequencer accepts a load word.
- `burned`  out  1  contents complete; reads permitted.
- `r_en`  in  1  read request.
- `addr_in`  in  `$clog2(DATA_DEPTH)`  read address.
- `data_out`  out  `DATA_WIDTH`  read data, unit 0 in the LSBs.
- `r_valid`  out  1  `data_out` valid.
- `r_err`  out  1  one-cycle pulse for a rejected read.
- `parity_err`  out  1  only with `W_ROM_PARITY_EN`; see Configuration.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE → LOAD when `burn_in_en`=1. `unit_cnt` and `addr_cnt` are cleared on entry.
- In LOAD, `load_ready`=1. Each handshake (`load_valid & load_ready`) writes `load_data` to slice `unit_cnt` at `addr_cnt`.
- Load order is address-major, unit-minor: (a0,u0), (a0,u1) … (a0,u(N-1)), (a1,u0) and so on.
- `unit_cnt` wraps from N-1 to 0 and increments `addr_cnt`.
- The handshake on (`DATA_DEPTH`-1, N-1) moves the FSM to DONE.
- `burn_in_en` falling in LOAD aborts the sequence: the FSM returns to IDLE, counters clear, `burned` stays 0, and partial contents are don't-care.
- A handshake in the same cycle as the abort is still written.
- DONE is sticky until reset. `burned`=1 and `load_ready`=0 in DONE, and `burn_in_en` is ignored.
- A read is accepted when `r_en`=1, `burned`=1 and `addr_in` < `DATA_DEPTH`. All slices are read at `addr_in` and concatenated.
- A read is rejected when `r_en`=1 with `burned`=0, or with `addr_in` ≥ `DATA_DEPTH`. A rejected read gives an `r_err` pulse `READ_LATENCY` cycles later, `r_valid`=0, and `data_out` holds its previous value.
- Reads are fully pipelined: one per cycle, no backpressure.
- Reset mid-operation:
  - all outputs return to their reset values;
  - the FSM returns to IDLE and in-flight reads are dropped;
  - memory contents are not cleared but are not trusted, so a new burn-in is required.

## Timing
- Reset values: `burned`=0, `load_ready`=0, `r_valid`=0, `r_err`=0, `data_out`=0, `parity_err`=0.
- `load_ready` rises the cycle after IDLE→LOAD, i.e. one cycle after `burn_in_en` is sampled high.
- `burned` rises the cycle after the final handshake.
- Burn-in takes a minimum of `DATA_DEPTH`·N+1 cycles with `load_valid` held high.
- `READ_LATENCY`=1: registered slice output.
- `READ_LATENCY`=2: adds an output register stage, for the wide fan-out.
- `r_valid` and `r_err` are mutually exclusive each cycle.

## Configuration
- Macro: `W_ROM_PARITY_EN`.
- Defined:
  - each slice stores one extra even-parity bit per word, computed at load;
  - on every accepted read, each slice's parity is checked;
  - `parity_err` pulses coincident with `r_valid` if any slice mismatches, and `data_out` is still delivered.
- Undefined: there is no parity storage or check, and the `parity_err` port is absent.

## Structure
- Package `w_rom_pkg` holds:
  - the FSM state enum (`W_ROM_IDLE`, `W_ROM_LOAD`, `W_ROM_DONE`);
  - functions for `NUM_UNITS` and counter widths;
  - the legal-`READ_LATENCY` check, which raises an elaboration error under `MODE_SIM`.
- Sub-module `w_rom_unit`: one `UNIT_WIDTH` (+1 with parity) × `DATA_DEPTH` slice with a synchronous write port, a registered read port and an optional parity generator/checker. The top level generates N instances.

## Test plan
Bench parameters: `DATA_WIDTH`=32, `UNIT_WIDTH`=8, `DATA_DEPTH`=4 (16 load words).

- Burn-in bytes 0x00..0x0F with `load_valid` held high → `burned` rises after 17 cycles. `r_en` @addr 2 → `r_valid` with `data_out`=0x0B0A0908 one cycle later (`READ_LATENCY`=1).
- `r_en` before `burned` → `r_err` pulse, no `r_valid`, `data_out` stays 0.
- Back-to-back reads of addresses 3, 0, 1 with `READ_LATENCY`=2 → `r_valid` for three consecutive cycles starting 2 cycles later, with data 0x0F0E0D0C, 0x03020100, 0x07060504.
- `burn_in_en` dropped after 5 words, then re-asserted with a full 16-word load → the final contents match the second load and `burned` rises only after the 16th word.
- Bench `DATA_DEPTH`=3, `r_en` @addr 3 → `r_err`, no `r_valid`. Then `rst_b` pulsed low during a pending read → the read is dropped and `burned` is 0.
- With `W_ROM_PARITY_EN`, force one stored bit flip in unit 1 @addr 0 → `parity_err` pulses together with `r_valid`.
